// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - shared types and the redirect/PC-control interface for pc_sequencer
package pc_sequencer_pkg;
    typedef struct packed {
        logic clk;
        logic resetn;
    } Util_Control_T;

    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } Pc_Action_T;
endpackage

interface pc_sequencer_if #(
    parameter int OFFSET_W = 16,
    parameter int JUMP_W   = 26,
    parameter int DEPTH    = 2
);
    import pc_sequencer_pkg::*;

    logic                stall;
    logic                br_valid;
    logic [OFFSET_W-1:0] br_offset;
    logic                jmp_valid;
    logic [JUMP_W-1:0]   jmp_target;

    Pc_Action_T          act;
    logic [OFFSET_W-1:0] offset;
    logic [JUMP_W-1:0]   jump;
    logic [DEPTH-1:0]    flush;
    logic                pending;

    modport slave (
        input  stall, br_valid, br_offset, jmp_valid, jmp_target,
        output act, offset, jump, flush, pending
    );

    modport master (
        output stall, br_valid, br_offset, jmp_valid, jmp_target,
        input  act, offset, jump, flush, pending
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC action sequencer: redirect arbitration, stall holds, deferred redirects, flushes
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int OFFSET_W = 16,
    parameter int JUMP_W   = 26,
    parameter int DEPTH    = 2
) (
    input  Util_Control_T  ctrl,
    pc_sequencer_if.slave  seq
);

    typedef enum logic {ST_RUN, ST_PEND} state_e;
    typedef enum logic {KIND_BR, KIND_JMP} kind_e;

    state_e              state_q, state_d;
    kind_e               kind_q, kind_d;
    logic [OFFSET_W-1:0] pend_offset_q, pend_offset_d;
    logic [JUMP_W-1:0]   pend_target_q, pend_target_d;

    Pc_Action_T          act_o;
    logic [OFFSET_W-1:0] offset_o;
    logic [JUMP_W-1:0]   jump_o;
    logic [DEPTH-1:0]    flush_o;
    logic                pending_o;
    logic [OFFSET_W-1:0] br_corrected;

    // The branch offset is relative to the branch PC+4, but the PC register sits DEPTH stages ahead.
    assign br_corrected = seq.br_offset + OFFSET_W'(1) - OFFSET_W'(DEPTH);

    always_ff @(posedge ctrl.clk) begin
        if (!ctrl.resetn) begin
            state_q       <= ST_RUN;
            kind_q        <= KIND_BR;
            pend_offset_q <= '0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            pend_offset_q <= pend_offset_d;
            pend_target_q <= pend_target_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        pend_offset_d = pend_offset_q;
        pend_target_d = pend_target_q;
        act_o         = PC_INC;
        offset_o      = '0;
        jump_o        = '0;
        flush_o       = '0;
        pending_o     = 1'b0;

        if (!ctrl.resetn) begin
            flush_o = '1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (!seq.stall) begin
                        if (seq.br_valid) begin
                            act_o    = PC_BRANCH;
                            offset_o = br_corrected;
                            flush_o  = '1;
                        end else if (seq.jmp_valid) begin
                            act_o   = PC_JUMP;
                            jump_o  = seq.jmp_target;
                            flush_o = DEPTH'(1);
                        end
                    end else begin
                        // Branch with a zero offset keeps the PC on its current address.
                        act_o = PC_BRANCH;
                        if (seq.br_valid) begin
                            state_d       = ST_PEND;
                            kind_d        = KIND_BR;
                            pend_offset_d = br_corrected;
                        end else if (seq.jmp_valid) begin
                            state_d       = ST_PEND;
                            kind_d        = KIND_JMP;
                            pend_target_d = seq.jmp_target;
                        end
                    end
                end
                ST_PEND: begin
                    pending_o = 1'b1;
                    if (seq.stall) begin
                        act_o = PC_BRANCH;
                        // An older branch in EX outranks a younger jump from ID.
                        if (seq.br_valid && kind_q == KIND_JMP) begin
                            kind_d        = KIND_BR;
                            pend_offset_d = br_corrected;
                        end
                    end else begin
                        state_d = ST_RUN;
                        if (kind_q == KIND_BR) begin
                            act_o    = PC_BRANCH;
                            offset_o = pend_offset_q;
                            flush_o  = '1;
                        end else begin
                            act_o   = PC_JUMP;
                            jump_o  = pend_target_q;
                            flush_o = DEPTH'(1);
                        end
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign seq.act     = act_o;
    assign seq.offset  = offset_o;
    assign seq.jump    = jump_o;
    assign seq.flush   = flush_o;
    assign seq.pending = pending_o;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control block that drives the PC register's action, offset and jump inputs every cycle.
- Arbitrates between two redirect sources: branch resolved in EX, jump decoded in ID.
- Converts pipeline stalls into PC holds, and defers any redirect that arrives during a stall until the stall clears.
- Emits per-stage flush pulses for wrong-path instructions; sits between hazard/decode/execute logic and the PC register.

Parameters:
- OFFSET_W, 16: branch offset width, in words.
- JUMP_W, 26: jump target field width.
- DEPTH, 2: stage distance from fetch (stage 0) to branch resolve (EX); must be >= 1.

Ports:
- ctrl  input  Util_Control_T  control bundle; clock field is the single clock (rising edge); reset field is synchronous, active-low.
- stall  input  1  pipeline freeze request from hazard unit.
- br_valid  input  1  taken branch in EX.
- br_offset  input  OFFSET_W  signed word offset, relative to branch PC+4.
- jmp_valid  input  1  jump decoded in ID.
- jmp_target  input  JUMP_W  word-address jump field.
- act  output  Pc_Action_T  PC action.
- offset  output  OFFSET_W  offset presented to the PC.
- jump  output  JUMP_W  jump field presented to the PC.
- flush  output  DEPTH  bit i kills the instruction in stage i (0 = IF).
- pending  output  1  a redirect is latched and awaiting stall release.

Behaviour:
- States: RUN, PEND. Registers: state, pend_kind (BR/JMP), pend_offset, pend_target.
- Outputs are combinational from state and inputs; only state/pending registers are clocked.
- Reset (reset field low at a rising edge):
  - state=RUN; pending registers cleared; pending=0.
  - While reset is low: act=Inc, offset=0, jump=0, flush=all ones.
- Hold encoding: act=Branch with offset=0. This makes the PC's next address equal its current address.
- Branch correction:
  - Issued offset = br_offset + 1 - DEPTH, computed modulo 2^OFFSET_W (two's complement wrap).
  - Result: target = branchPC + 4 + 4*br_offset.
  - Correction is applied when the branch is latched; pend_offset stores the corrected value.
- RUN, stall=0:
  - If br_valid: act=Branch, offset=corrected, flush = all DEPTH bits. Any simultaneous jmp_valid is dropped (wrong path).
  - Else if jmp_valid: act=Jump, jump=jmp_target, flush = bit 0 only.
  - Else: act=Inc, offset=0, flush=0.
  - Stay in RUN.
- RUN, stall=1:
  - Outputs: hold, flush=0.
  - If br_valid: latch BR with corrected offset, go to PEND.
  - Else if jmp_valid: latch JMP, go to PEND.
  - Else stay in RUN.
- PEND, stall=1:
  - Outputs: hold, flush=0, pending=1.
  - A br_valid arriving while a JMP is pending replaces it with BR.
  - A br_valid while a BR is pending is ignored (same frozen instruction).
  - jmp_valid is ignored.
- PEND, stall=0:
  - Issue the pending redirect with the same act/offset/jump/flush as the RUN case for that kind.
  - br_valid/jmp_valid are ignored this cycle (frozen instructions, killed by this flush).
  - Next state RUN; pending=0 from the next cycle.
- A redirect is issued exactly once per latch; there are never two redirects in back-to-back cycles from one held valid.
- Reset mid-PEND discards the pending redirect.
- jump output is 0 whenever act is not Jump. offset output is 0 whenever act is not Branch (hold included).

Test Plan:
1. Reset low 3 cycles, then high, no requests → act=Inc every cycle; flush all ones only while reset is low; PC steps 0,4,8.
2. DEPTH=2, RUN, br_valid with br_offset=5 → same cycle act=Branch, offset=4, flush=2'b11. With the branch at 0x100, PC next=0x118.
3. Jump and branch in the same cycle: jmp_valid with jmp_target=0x40, plus br_valid with br_offset=-3 → Branch with offset=0xFFFC, flush=11; jump dropped.
4. Stall 3 cycles with br_valid held throughout, br_offset=2 → 3 hold cycles (Branch, offset=0, flush=0, pending=1 from the second cycle). On the stall-release cycle: Branch, offset=1, flush=11. Next cycle act=Inc.
5. Pending JMP overridden: stall with jmp_valid (target 0x80), then br_valid on the 2nd stall cycle → release issues Branch; no Jump is ever issued.
6. Reset asserted while in PEND → pending=0 and state=RUN after the edge; with reset released and no requests, act=Inc and no redirect is issued.
